// File: rtl/sample_ring_buffer.sv
// Logic-analyzer style sample capture ring with pre/post-trigger window, exposed
// through a 2-cycle pass-through register bus.
module sample_ring_buffer #(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int SAMPLE_WIDTH = 16,
    parameter int TRIGGER_LOC  = SAMPLE_DEPTH / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] probes,
    input  logic                    trigger,
    output logic [1:0]              state,
    input  logic [15:0]             addr_i,
    input  logic [15:0]             wdata_i,
    input  logic [15:0]             rdata_i,
    input  logic                    rw_i,
    input  logic                    valid_i,
    output logic [15:0]             addr_o,
    output logic [15:0]             wdata_o,
    output logic [15:0]             rdata_o,
    output logic                    rw_o,
    output logic                    valid_o
);
    localparam int W      = (SAMPLE_WIDTH + 15) / 16;
    localparam int WW     = (W > 1) ? $clog2(W) : 1;
    localparam int AW     = $clog2(SAMPLE_DEPTH);
    localparam int NWORDS = SAMPLE_DEPTH * W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_FILLING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(SAMPLE_DEPTH);

    logic [1:0]              r_state;
    logic [AW-1:0]           r_wptr, r_trig_addr, r_tloc;
    logic [AW:0]             r_fill, r_post;
    logic [SAMPLE_WIDTH-1:0] r_mem [SAMPLE_DEPTH];
    logic [SAMPLE_WIDTH-1:0] r_memq;

    logic [15:0]   r_addr1, r_wdata1, r_rdata1, r_regval1;
    logic          r_rw1, r_valid1, r_own1, r_selmem1;
    logic [WW-1:0] r_word1;
    logic [15:0]   r_addr_o, r_wdata_o, r_rdata_o;
    logic          r_rw_o, r_valid_o;

    logic [16:0]         w_diff;
    logic [31:0]         w_off, w_soff;
    logic                w_owned, w_is_sample, w_rd, w_wr, w_idle_or_done, w_capture, w_trig_ok, w_post_last;
    logic [AW-1:0]       w_sidx, w_raddr;
    logic [WW-1:0]       w_sword;
    logic [15:0]         w_regval, w_word;
    logic [W*16-1:0]     w_pad;

    // Bit 16 of the difference is the borrow, i.e. the address lies below the block.
    assign w_diff      = {1'b0, addr_i} - 17'(BASE_ADDR);
    assign w_off       = {16'd0, w_diff[15:0]};
    assign w_owned     = !w_diff[16] && (w_off < 32'(4 + NWORDS));
    assign w_is_sample = w_owned && (w_off >= 32'd4);
    assign w_soff      = w_off - 32'd4;
    assign w_sidx      = AW'(w_soff / 32'(W));
    assign w_sword     = WW'(w_soff % 32'(W));
    assign w_raddr     = r_trig_addr - r_tloc + w_sidx;
    assign w_rd        = valid_i && !rw_i;
    assign w_wr        = valid_i && rw_i;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_capture      = (r_state == ST_ARMED) || (r_state == ST_FILLING);
    assign w_trig_ok      = trigger && (r_fill >= {1'b0, r_tloc});
    assign w_post_last    = (r_post + 1'b1) == (DEPTH_C - {1'b0, r_tloc});

    always_comb begin
        w_regval = '0;
        if (!w_is_sample) begin
            case (w_off)
                32'd0:   w_regval = {14'd0, r_state};
                32'd1:   w_regval = 16'(r_tloc);
                default: w_regval = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wptr      <= '0;
            r_fill      <= '0;
            r_post      <= '0;
            r_trig_addr <= '0;
            r_tloc      <= AW'(TRIGGER_LOC);
        end else begin
            if (w_wr && w_owned && (w_off == 32'd1) && w_idle_or_done)
                r_tloc <= ({16'd0, wdata_i} > 32'(SAMPLE_DEPTH - 1)) ? AW'(SAMPLE_DEPTH - 1) : AW'(wdata_i);

            if (w_wr && w_owned && (w_off == 32'd3)) begin
                r_state <= ST_IDLE;
            end else if (w_wr && w_owned && (w_off == 32'd2) && w_idle_or_done) begin
                r_state <= ST_ARMED;
                r_wptr  <= '0;
                r_fill  <= '0;
                r_post  <= '0;
            end else if (w_capture) begin
                r_wptr <= r_wptr + 1'b1;
                if (r_fill != DEPTH_C)
                    r_fill <= r_fill + 1'b1;
                // The trigger cycle itself counts as post-trigger sample 0.
                if (r_state == ST_FILLING || w_trig_ok) begin
                    if (r_state == ST_ARMED)
                        r_trig_addr <= r_wptr;
                    r_post  <= r_post + 1'b1;
                    r_state <= w_post_last ? ST_DONE : ST_FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_capture)
            r_mem[r_wptr] <= probes;
    end

    always_ff @(posedge clk) begin
        if (rst) r_memq <= '0;
        else     r_memq <= r_mem[w_raddr];
    end

    always_comb begin
        w_pad = '0;
        w_pad[SAMPLE_WIDTH-1:0] = r_memq;
        w_word = '0;
        for (int unsigned j = 0; j < W; j++)
            if (r_word1 == WW'(j)) w_word = w_pad[j*16 +: 16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr1   <= '0;
            r_wdata1  <= '0;
            r_rdata1  <= '0;
            r_rw1     <= 1'b0;
            r_valid1  <= 1'b0;
            r_own1    <= 1'b0;
            r_selmem1 <= 1'b0;
            r_regval1 <= '0;
            r_word1   <= '0;
            r_addr_o  <= '0;
            r_wdata_o <= '0;
            r_rdata_o <= '0;
            r_rw_o    <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            r_addr1   <= addr_i;
            r_wdata1  <= wdata_i;
            r_rdata1  <= rdata_i;
            r_rw1     <= rw_i;
            r_valid1  <= valid_i;
            r_own1    <= w_rd && w_owned;
            r_selmem1 <= w_rd && w_is_sample && (r_state == ST_DONE);
            r_regval1 <= w_regval;
            r_word1   <= w_sword;
            r_addr_o  <= r_addr1;
            r_wdata_o <= r_wdata1;
            r_rdata_o <= !r_own1 ? r_rdata1 : (r_selmem1 ? w_word : r_regval1);
            r_rw_o    <= r_rw1;
            r_valid_o <= r_valid1;
        end
    end

    assign state   = r_state;
    assign addr_o  = r_addr_o;
    assign wdata_o = r_wdata_o;
    assign rdata_o = r_rdata_o;
    assign rw_o    = r_rw_o;
    assign valid_o = r_valid_o;

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Scoreboard bench for sample_ring_buffer: directed bus/capture vectors, monitor
// pops expected bus responses whenever valid_o is seen.
module tb_sample_ring_buffer;
    localparam int BASE  = 256;
    localparam int DEPTH = 8;
    localparam int WIDTH = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] probes;
    logic             trigger;
    logic [1:0]       state;
    logic [15:0]      addr_i, wdata_i, rdata_i, addr_o, wdata_o, rdata_o;
    logic             rw_i, valid_i, rw_o, valid_o;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        rw;
        logic [31:0] due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_ring_buffer #(
        .BASE_ADDR   (BASE),
        .SAMPLE_DEPTH(DEPTH),
        .SAMPLE_WIDTH(WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .probes (probes),
        .trigger(trigger),
        .state  (state),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .rdata_i(rdata_i),
        .rw_i   (rw_i),
        .valid_i(valid_i),
        .addr_o (addr_o),
        .wdata_o(wdata_o),
        .rdata_o(rdata_o),
        .rw_o   (rw_o),
        .valid_o(valid_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd,
                         input logic rw, input logic [15:0] exp_rd);
        exp_t e;
        addr_i  = a;
        wdata_i = wd;
        rdata_i = rd;
        rw_i    = rw;
        valid_i = 1'b1;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = exp_rd;
        e.rw    = rw;
        e.due   = cyc + 2;
        q.push_back(e);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        rw_i    = 1'b0;
        addr_i  = 16'h7777;
        wdata_i = 16'h3333;
        rdata_i = 16'h4444;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        drive(16'(a), d, 16'h5A5A, 1'b1, 16'h5A5A);
    endtask

    task automatic rd(input int a, input logic [15:0] rdi, input logic [15:0] exp);
        @(negedge clk);
        drive(16'(a), 16'h1111, rdi, 1'b0, exp);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        idle();
        repeat (n) @(negedge clk);
    endtask

    // probes = {hi, counter}, counter 0 on the first ARMED cycle after the start write.
    task automatic capture(input int tl, input int trig_at, input bit hold, input int stop_at,
                           input int ncyc, input logic [3:0] hi);
        int acc  = hold ? tl : trig_at;
        int post = DEPTH - tl;
        @(negedge clk);
        drive(16'(BASE + 2), 16'h0001, 16'h0F0F, 1'b1, 16'h0F0F);
        trigger = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == stop_at) drive(16'(BASE + 3), 16'h0000, 16'h0F0F, 1'b1, 16'h0F0F);
            else              idle();
            probes  = {hi, 16'(c)};
            trigger = hold || (c == trig_at);
            if (stop_at >= 0) begin
                if (c == stop_at + 1) chk("state_after_stop", 32'(state), 32'd0);
            end else begin
                if (c == acc)                   chk("state_armed_at_trig", 32'(state), 32'd1);
                if (c == acc + 1 && post > 1)   chk("state_filling", 32'(state), 32'd2);
                if (c == acc + post - 1 && post > 1) chk("state_before_done", 32'(state), 32'd2);
                if (c == acc + post)            chk("state_done", 32'(state), 32'd3);
            end
        end
        @(negedge clk);
        idle();
        trigger = 1'b0;
    endtask

    task automatic read_samples(input int first, input logic [3:0] hi);
        for (int i = 0; i < DEPTH; i++) begin
            rd(BASE + 4 + 2 * i, 16'hA5A5, 16'(first + i));
            rd(BASE + 5 + 2 * i, 16'hA5A5, {12'd0, hi});
        end
        gap(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL bus_out: unexpected valid_o addr %h", addr_o);
            end else begin
                e = q.pop_front();
                if ({addr_o, wdata_o, rdata_o, rw_o} !== {e.addr, e.wdata, e.rdata, e.rw} ||
                    cyc != int'(e.due)) begin
                    errors++;
                    $display("FAIL bus_out: got addr %h wdata %h rdata %h rw %b cyc %0d, expected addr %h wdata %h rdata %h rw %b cyc %0d",
                             addr_o, wdata_o, rdata_o, rw_o, cyc, e.addr, e.wdata, e.rdata, e.rw, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        probes  = '1;
        trigger = 1'b1;
        valid_i = 1'b1;
        rw_i    = 1'b0;
        addr_i  = 16'(BASE);
        wdata_i = 16'hFFFF;
        rdata_i = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        idle();
        trigger = 1'b0;
        probes  = '0;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_addr_o", 32'(addr_o), 32'd0);
        chk("rst_rdata_o", 32'(rdata_o), 32'd0);
        chk("rst_wdata_o", 32'(wdata_o), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

        rd(BASE + 0, 16'hA5A5, 16'd0);
        rd(BASE + 1, 16'hA5A5, 16'd4);
        rd(BASE + 4, 16'hA5A5, 16'd0);
        rd(BASE + 50, 16'hBEEF, 16'hBEEF);
        rd(BASE - 1, 16'h1357, 16'h1357);
        rd(BASE + 20, 16'h2468, 16'h2468);

        wr(BASE + 1, 16'd100);
        rd(BASE + 1, 16'hA5A5, 16'd7);
        wr(BASE + 2, 16'd1);
        wr(BASE + 1, 16'd2);
        rd(BASE + 1, 16'hA5A5, 16'd7);
        wr(BASE + 0, 16'd3);
        rd(BASE + 0, 16'hA5A5, 16'd1);
        wr(BASE + 3, 16'd0);
        rd(BASE + 0, 16'hA5A5, 16'd0);
        wr(BASE + 1, 16'd3);
        rd(BASE + 1, 16'hA5A5, 16'd3);
        gap(2);

        capture(3, 5, 1'b0, -1, 12, 4'h0);
        rd(BASE + 0, 16'hA5A5, 16'd3);
        read_samples(2, 4'h0);

        capture(3, -1, 1'b1, -1, 10, 4'h0);
        read_samples(0, 4'h0);

        capture(3, 20, 1'b0, -1, 27, 4'h0);
        read_samples(17, 4'h0);

        capture(3, 5, 1'b0, 7, 10, 4'h0);
        rd(BASE + 0, 16'hA5A5, 16'd0);
        rd(BASE + 4, 16'hA5A5, 16'd0);
        rd(BASE + 10, 16'hA5A5, 16'd0);
        gap(1);

        wr(BASE + 1, 16'd0);
        gap(1);
        capture(0, 0, 1'b0, -1, 10, 4'h5);
        read_samples(0, 4'h5);
        rd(BASE + 50, 16'hBEEF, 16'hBEEF);

        gap(4);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_ring_buffer.md
SAMPLE_RING_BUFFER -- requirements
Module: sample_ring_buffer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: first bus address of the block.
REQ-002 SHALL have parameter SAMPLE_DEPTH, default 1024: samples stored; power of two, 4..65536.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 16: probe bits per sample, 1..64; W = ceil(SAMPLE_WIDTH/16) words per sample.
REQ-004 SHALL have parameter TRIGGER_LOC, default SAMPLE_DEPTH/2: reset value of the pre-trigger sample count.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port probes, input, SAMPLE_WIDTH bits: sample captured each acquiring cycle.
REQ-008 SHALL have port trigger, input, 1 bit: trigger condition from the trigger block.
REQ-009 SHALL have port state, output, 2 bits: current FSM state, IDLE=0, ARMED=1, FILLING=2, DONE=3.
REQ-010 SHALL have ports addr_i, wdata_i, rdata_i, input, 16 bits each: bus in.
REQ-011 SHALL have ports rw_i, valid_i, input, 1 bit each: bus in; rw=1 is write.
REQ-012 SHALL have ports addr_o, wdata_o, rdata_o, output, 16 bits each, and rw_o, valid_o, output, 1 bit each: registered bus out.

Function
REQ-013 SHALL pass every bus field from input to output with exactly 2 cycles latency, unmodified except rdata_o on owned reads.
REQ-014 SHALL own registers BASE_ADDR+0 state (RO), +1 trigger_loc (RW), +2 start (WO), +3 stop (WO), and sample data at BASE_ADDR+4 .. BASE_ADDR+3+SAMPLE_DEPTH*W.
REQ-015 SHALL, on a read (valid, rw=0) of an owned address, replace rdata_o with the addressed value 2 cycles later; writes to RO or sample addresses are ignored.
REQ-016 SHALL ignore trigger_loc writes unless in IDLE or DONE; written values above SAMPLE_DEPTH-1 saturate to SAMPLE_DEPTH-1.
REQ-017 SHALL on any write to start in IDLE or DONE: clear write pointer and fill count to 0, enter ARMED next cycle; ignored in ARMED/FILLING.
REQ-018 SHALL on any write to stop enter IDLE next cycle from any state; stop wins over start and trigger in the same cycle.
REQ-019 SHALL in ARMED and FILLING write probes into the ring at the write pointer every cycle, pointer incrementing mod SAMPLE_DEPTH; fill count saturates at SAMPLE_DEPTH.
REQ-020 SHALL in ARMED ignore trigger while fill count < trigger_loc; otherwise trigger=1 latches trigger address = current write pointer and enters FILLING.
REQ-021 SHALL treat the trigger-cycle sample as post-trigger sample 0 and enter DONE after exactly SAMPLE_DEPTH-trigger_loc post-trigger samples, writing nothing in DONE.
REQ-022 SHALL map sample index i (0..SAMPLE_DEPTH-1) to ring address (trigger address - trigger_loc + i) mod SAMPLE_DEPTH, so index trigger_loc is the trigger sample.
REQ-023 SHALL return at BASE_ADDR+4+i*W+j bits [16j+15:16j] of sample i, upper bits of the last word zero-padded.
REQ-024 SHALL return 0 for sample-data reads when state is not DONE.
REQ-025 SHALL use storage with 2-cycle read latency so read data aligns with the bus pipeline; simultaneous sample write and bus read SHALL NOT stall either.
REQ-026 SHALL with trigger_loc=0 accept trigger on the first ARMED cycle and fill SAMPLE_DEPTH post-trigger samples.

Reset
REQ-027 SHALL on rst: state IDLE, write pointer, fill count and trigger address 0, trigger_loc=TRIGGER_LOC, all bus outputs and pipeline stages 0.
REQ-028 SHALL on rst mid-capture abort immediately; stored samples are undefined afterwards.

Verification
REQ-029 SHALL pass: DEPTH=8, WIDTH=20, trigger_loc=3, probes=cycle counter from 0 after start, trigger at counter 5 -> DONE after counter 9; reads give indices 0..7 = 2..9, word 1 of index 3 = 0.
REQ-030 SHALL pass: trigger held high from start with trigger_loc=3 -> accepted at counter 3; indices 0..7 = 0..7.
REQ-031 SHALL pass: trigger at counter 20 (ring wrapped), trigger_loc=3 -> indices 0..7 = 17..24.
REQ-032 SHALL pass: stop written during FILLING -> state reads 0 two cycles after read issue; sample reads return 0.
REQ-033 SHALL pass: trigger_loc write of 100 in IDLE -> reads back 7; write of 2 in ARMED -> remains 7.
REQ-034 SHALL pass: read of BASE_ADDR+50 with rdata_i=0xBEEF (not owned) -> rdata_o=0xBEEF after 2 cycles, valid_o=1.
